// File: rtl/mul8u_dot_acc_pkg.sv
// Shared widths and beat type for the streaming 8x8 multiply-accumulate slice.
// Imported by the interface, the multiplier wrapper and the top.
package mul8u_pkg;

    localparam int ACC_W_DEF = 24;
    localparam int CNT_W_DEF = 9;
    localparam int OP_W      = 8;
    localparam int PROD_W    = 16;

    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
        logic            last;
    } mul8u_beat_t;

endpackage

// File: rtl/mul8u_dot_acc_if.sv
// Operand stream in, dot-product result stream out.
// The producer/consumer side is the master; the accumulator is the slave.
interface mul8u_dot_acc_if
    import mul8u_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
);

    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  in_a;
    logic [OP_W-1:0]  in_b;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );

endinterface

// File: rtl/mul8u_dot_acc_mul.sv
// Exact 8x8 unsigned multiplier; approximate variants share this port list
// and are swapped in by name at build time.
module mul8u_exact (
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic [15:0] O
);

    assign O = {8'd0, A} * {8'd0, B};

endmodule

// File: rtl/mul8u_dot_acc.sv
// Streaming dot-product accumulator: register operands, multiply, register the
// product, accumulate, and emit one sum/count/overflow triple per vector.
`ifndef MUL8U_MUL_MODULE
`define MUL8U_MUL_MODULE mul8u_exact
`endif

module mul8u_dot_acc
    import mul8u_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    mul8u_dot_acc_if.slave bus
);

    mul8u_beat_t       w_beat;
    mul8u_beat_t       r_s1;
    logic              r_s1_v;
    logic [PROD_W-1:0] w_prod;
    logic [PROD_W-1:0] r_s2_p;
    logic              r_s2_v;
    logic              r_s2_last;
    logic [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_ovf;
    logic [ACC_W-1:0]  r_out_sum;
    logic [CNT_W-1:0]  r_out_count;
    logic              r_out_ovf;
    logic              r_out_valid;

    logic              w_stall;
    logic              w_adv;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_fire;
    logic              w_done;
    logic [ACC_W:0]    w_sum;
    logic              w_ovf_n;
    logic [CNT_W-1:0]  w_cnt_n;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    // Pack the incoming beat.
    always_comb begin
        w_beat      = '0;
        w_beat.a    = bus.in_a;
        w_beat.b    = bus.in_b;
        w_beat.last = bus.in_last;
    end

    // Only a finished vector waiting on an unready consumer freezes the pipe.
    always_comb begin
        w_stall    = r_s2_v && r_s2_last && r_out_valid && !bus.out_ready;
        w_adv      = !w_stall;
        w_in_ready = w_adv && !rst;
        w_accept   = bus.in_valid && w_in_ready;
        w_fire     = r_s2_v && w_adv;
        w_done     = w_fire && r_s2_last;
    end

    // Next accumulator state; the extra top bit of the sum is the carry-out.
    always_comb begin
        w_sum   = {1'b0, r_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, r_s2_p};
        w_ovf_n = r_ovf | w_sum[ACC_W];
        w_cnt_n = sat_inc(r_cnt);
    end

    `MUL8U_MUL_MODULE u_mul (
        .A (r_s1.a),
        .B (r_s1.b),
        .O (w_prod)
    );

    // Operand register stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_v <= 1'b0;
            r_s1   <= '0;
        end else if (w_adv) begin
            r_s1_v <= w_accept;
            if (w_accept) begin
                r_s1 <= w_beat;
            end
        end
    end

    // Product register stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_v    <= 1'b0;
            r_s2_p    <= '0;
            r_s2_last <= 1'b0;
        end else if (w_adv) begin
            r_s2_v    <= r_s1_v;
            r_s2_p    <= w_prod;
            r_s2_last <= r_s1.last;
        end
    end

    // Running sum, beat count and sticky carry for the vector in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_fire) begin
            if (r_s2_last) begin
                r_acc <= '0;
                r_cnt <= '0;
                r_ovf <= 1'b0;
            end else begin
                r_acc <= w_sum[ACC_W-1:0];
                r_cnt <= w_cnt_n;
                r_ovf <= w_ovf_n;
            end
        end
    end

    // Result register: a completing vector reloads even on the handshake cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_count <= '0;
            r_out_ovf   <= 1'b0;
        end else if (w_done) begin
            r_out_valid <= 1'b1;
            r_out_sum   <= w_sum[ACC_W-1:0];
            r_out_count <= w_cnt_n;
            r_out_ovf   <= w_ovf_n;
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sum   = r_out_sum;
    assign bus.out_count = r_out_count;
    assign bus.out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_mul8u_dot_acc.sv
// Scoreboard bench: a 24-bit and a 16-bit accumulator share one operand stream;
// a reference model queues expected results and a monitor checks each output.
module tb_mul8u_dot_acc;
    import mul8u_pkg::*;

    typedef struct {
        longint sum;
        longint cnt;
        longint ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_last;
    logic       out_ready;
    bit         rnd_ready;

    int     errors = 0;
    int     checks = 0;
    exp_t   q24[$];
    exp_t   q16[$];
    exp_t   e;
    longint v_sum;
    longint v_cnt;
    bit     hold24, hold16;
    longint h24_sum, h24_cnt, h24_ovf, h16_sum, h16_cnt, h16_ovf;

    always #5 clk = ~clk;

    mul8u_dot_acc_if #(.ACC_W(24), .CNT_W(9)) if24 ();
    mul8u_dot_acc_if #(.ACC_W(16), .CNT_W(9)) if16 ();

    assign if24.in_valid  = in_valid;
    assign if24.in_a      = in_a;
    assign if24.in_b      = in_b;
    assign if24.in_last   = in_last;
    assign if24.out_ready = out_ready;
    assign if16.in_valid  = in_valid;
    assign if16.in_a      = in_a;
    assign if16.in_b      = in_b;
    assign if16.in_last   = in_last;
    assign if16.out_ready = out_ready;

    mul8u_dot_acc #(.ACC_W(24), .CNT_W(9)) dut24 (.clk(clk), .rst(rst), .bus(if24.slave));
    mul8u_dot_acc #(.ACC_W(16), .CNT_W(9)) dut16 (.clk(clk), .rst(rst), .bus(if16.slave));

    function automatic void chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endfunction

    function automatic exp_t make_exp(input longint total, input longint n, input int w);
        exp_t r;
        r.sum = total % (64'd1 << w);
        r.cnt = (n > 511) ? 511 : n;
        r.ovf = (total >= (64'd1 << w)) ? 1 : 0;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic l);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = l;
        for (int k = 0; k < 2000 && !done; k++) begin
            @(negedge clk);
            done = if24.in_ready;
            tick();
        end
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL send_timeout: got no acceptance, expected acceptance within 2000 cycles");
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = 8'd0;
        in_b      = 8'd0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        rnd_ready = 1'b0;
        v_sum     = 0;
        v_cnt     = 0;
        hold24    = 1'b0;
        hold16    = 1'b0;

        fork
            forever begin
                @(negedge clk);
                // Held results must not move while the consumer is not ready.
                if (hold24) begin
                    chk("d24_hold_valid", longint'(if24.out_valid), 1);
                    chk("d24_hold_sum", longint'(if24.out_sum), h24_sum);
                    chk("d24_hold_cnt", longint'(if24.out_count), h24_cnt);
                    chk("d24_hold_ovf", longint'(if24.out_ovf), h24_ovf);
                end
                if (hold16) begin
                    chk("d16_hold_sum", longint'(if16.out_sum), h16_sum);
                    chk("d16_hold_ovf", longint'(if16.out_ovf), h16_ovf);
                end
                if (rst) begin
                    chk("d24_ready_in_rst", longint'(if24.in_ready), 0);
                    chk("d16_ready_in_rst", longint'(if16.in_ready), 0);
                end else begin
                    if (!if24.out_valid) chk("d24_ready_idle", longint'(if24.in_ready), 1);
                    if (!if16.out_valid) chk("d16_ready_idle", longint'(if16.in_ready), 1);
                    if (if24.out_valid && out_ready) begin
                        if (q24.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL d24_unexpected: got sum %0d, expected no result", if24.out_sum);
                        end else begin
                            e = q24.pop_front();
                            chk("d24_sum", longint'(if24.out_sum), e.sum);
                            chk("d24_cnt", longint'(if24.out_count), e.cnt);
                            chk("d24_ovf", longint'(if24.out_ovf), e.ovf);
                        end
                    end
                    if (if16.out_valid && out_ready) begin
                        if (q16.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL d16_unexpected: got sum %0d, expected no result", if16.out_sum);
                        end else begin
                            e = q16.pop_front();
                            chk("d16_sum", longint'(if16.out_sum), e.sum);
                            chk("d16_cnt", longint'(if16.out_count), e.cnt);
                            chk("d16_ovf", longint'(if16.out_ovf), e.ovf);
                        end
                    end
                end
                hold24  = !rst && if24.out_valid && !out_ready;
                h24_sum = longint'(if24.out_sum);
                h24_cnt = longint'(if24.out_count);
                h24_ovf = longint'(if24.out_ovf);
                hold16  = !rst && if16.out_valid && !out_ready;
                h16_sum = longint'(if16.out_sum);
                h16_cnt = longint'(if16.out_count);
                h16_ovf = longint'(if16.out_ovf);
                // Reference model: reset discards everything, else track the accepted beat.
                if (rst) begin
                    q24.delete();
                    q16.delete();
                    v_sum = 0;
                    v_cnt = 0;
                end else if (in_valid && if24.in_ready) begin
                    v_sum += longint'(in_a) * longint'(in_b);
                    v_cnt += 1;
                    if (in_last) begin
                        q24.push_back(make_exp(v_sum, v_cnt, 24));
                        q16.push_back(make_exp(v_sum, v_cnt, 16));
                        v_sum = 0;
                        v_cnt = 0;
                    end
                end
            end
        join_none

        // Reset values.
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_valid", longint'(if24.out_valid), 0);
        chk("rst_sum", longint'(if24.out_sum), 0);
        chk("rst_cnt", longint'(if24.out_count), 0);
        chk("rst_ovf", longint'(if24.out_ovf), 0);
        chk("rst_valid16", longint'(if16.out_valid), 0);
        tick();
        rst = 1'b0;

        // Basic vector with latency check.
        send(8'd3, 8'd5, 1'b0);
        send(8'd7, 8'd9, 1'b0);
        send(8'd255, 8'd255, 1'b1);
        @(negedge clk);
        chk("lat_e0", longint'(if24.out_valid), 0);
        tick();
        @(negedge clk);
        chk("lat_e1", longint'(if24.out_valid), 0);
        tick();
        @(negedge clk);
        chk("lat_e2", longint'(if24.out_valid), 1);
        chk("basic_sum", longint'(if24.out_sum), 65103);
        tick();

        // Back-to-back single-beat vectors, no bubble.
        send(8'd200, 8'd100, 1'b1);
        send(8'd1, 8'd1, 1'b1);
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("b2b_valid0", longint'(if24.out_valid), 1);
        chk("b2b_sum0", longint'(if24.out_sum), 20000);
        tick();
        @(negedge clk);
        chk("b2b_valid1", longint'(if24.out_valid), 1);
        chk("b2b_sum1", longint'(if24.out_sum), 1);
        tick();
        tick();

        // Held result with the next vector backing up behind it.
        out_ready = 1'b0;
        send(8'd6, 8'd7, 1'b1);
        send(8'd2, 8'd2, 1'b0);
        send(8'd4, 8'd4, 1'b1);
        tick();
        @(negedge clk);
        chk("stall_ready", longint'(if24.in_ready), 0);
        chk("stall_sum", longint'(if24.out_sum), 42);
        tick();
        @(negedge clk);
        chk("stall_ready2", longint'(if24.in_ready), 0);
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_ready", longint'(if24.in_ready), 1);
        tick();
        @(negedge clk);
        chk("release_valid", longint'(if24.out_valid), 1);
        chk("release_sum", longint'(if24.out_sum), 20);
        tick();

        // Overflow in the 16-bit instance, then a clean vector.
        send(8'd255, 8'd255, 1'b0);
        send(8'd255, 8'd255, 1'b1);
        send(8'd1, 8'd1, 1'b1);
        repeat (4) tick();

        // Reset mid-vector with a pending result.
        out_ready = 1'b0;
        send(8'd5, 8'd5, 1'b1);
        send(8'd9, 8'd9, 1'b0);
        send(8'd8, 8'd8, 1'b0);
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("mid_rst_valid", longint'(if24.out_valid), 0);
        chk("mid_rst_sum", longint'(if24.out_sum), 0);
        chk("mid_rst_cnt", longint'(if24.out_count), 0);
        chk("mid_rst_valid16", longint'(if16.out_valid), 0);
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        send(8'd10, 8'd10, 1'b1);
        repeat (4) tick();

        // Random regression, including a saturating, a max-operand and a zero vector.
        rnd_ready = 1'b1;
        for (int v = 0; v < 40; v++) begin
            int len;
            len = $urandom_range(1, 20);
            if (v == 5) len = 600;
            if (v == 15) len = 300;
            for (int i = 0; i < len; i++) begin
                logic [7:0] ra, rb;
                ra = 8'($urandom_range(0, 255));
                rb = 8'($urandom_range(0, 255));
                if (v == 10) begin
                    ra = 8'd0;
                    rb = 8'd0;
                end
                if (v == 15) begin
                    ra = 8'd255;
                    rb = 8'd255;
                end
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
                send(ra, rb, (i == len - 1) ? 1'b1 : 1'b0);
            end
        end

        // Drain.
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 200 && (q24.size() != 0 || q16.size() != 0); k++) tick();
        repeat (2) tick();
        chk("drain_q24", longint'(q24.size()), 0);
        chk("drain_q16", longint'(q16.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
